// File: rtl/pe_out_requant.sv
// Output requantizer/serializer behind the Winograd PE core: groups -> ReLU/round-shift/saturate -> one X_PE pixel word per beat.
// Latency: in_valid at t -> FIFO write and pop at t+1 -> S1 at t+2 -> out_valid at t+3.
// Backpressure: out_valid && !out_ready freezes FSM/S1/S2; the group FIFO keeps accepting, drops when full (sticky overflow).
// Ports: clk/srst (sync, active-high); in_valid/poolop/result_unpool/result_pool from the PE core;
//        shift/relu_en quasi-static config; out_valid/out_ready/out_data/out_pix/out_last stream;
//        almost_full throttle hint (count >= DEPTH-2); overflow sticky drop flag.
module pe_out_requant #(
    parameter int OUT_BIT     = 24,
    parameter int DATA_BIT    = 8,
    parameter int RESULT_SIZE = 2,
    parameter int X_PE        = 16,
    parameter int DEPTH       = 8
) (
    input  logic                                             clk,
    input  logic                                             srst,
    input  logic                                             in_valid,
    input  logic                                             poolop,
    input  logic [OUT_BIT*RESULT_SIZE*RESULT_SIZE*X_PE-1:0]  result_unpool,
    input  logic [OUT_BIT*X_PE-1:0]                          result_pool,
    input  logic [4:0]                                       shift,
    input  logic                                             relu_en,
    input  logic                                             out_ready,
    output logic                                             out_valid,
    output logic [DATA_BIT*X_PE-1:0]                         out_data,
    output logic [1:0]                                       out_pix,
    output logic                                             out_last,
    output logic                                             almost_full,
    output logic                                             overflow
);
    localparam int NPIX    = RESULT_SIZE * RESULT_SIZE;
    localparam int GRP_W   = OUT_BIT * NPIX * X_PE;
    localparam int ENTRY_W = GRP_W + 1;
    localparam int AW      = $clog2(DEPTH);
    localparam int CW      = AW + 1;
    localparam logic signed [OUT_BIT:0] SAT_MAX = (OUT_BIT+1)'((1 << (DATA_BIT-1)) - 1);
    localparam logic signed [OUT_BIT:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    // ReLU, then round-half-up arithmetic shift; one extra bit keeps x + 2^(shift-1) from wrapping.
    function automatic logic signed [OUT_BIT:0] rq(input logic signed [OUT_BIT-1:0] x,
                                                   input logic [4:0] sh, input logic relu);
        logic signed [OUT_BIT:0] xe;
        logic signed [OUT_BIT:0] rnd;
        logic signed [OUT_BIT:0] sum;
        xe  = (relu && x[OUT_BIT-1]) ? '0 : {x[OUT_BIT-1], x};
        rnd = (sh != 5'd0) ? ((OUT_BIT+1)'(1) << (sh - 5'd1)) : '0;
        sum = xe + rnd;
        return sum >>> sh;
    endfunction

    function automatic logic [DATA_BIT-1:0] sat(input logic signed [OUT_BIT:0] y);
        if (y > SAT_MAX)      return SAT_MAX[DATA_BIT-1:0];
        else if (y < SAT_MIN) return SAT_MIN[DATA_BIT-1:0];
        else                  return y[DATA_BIT-1:0];
    endfunction

    // ---------------- group FIFO ----------------
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               wr_en, pop, stall, fifo_nempty, head_pool;
    logic [ENTRY_W-1:0] wr_dat, head;

    // Pooled groups reuse pixel-0 slots so the serializer reads one layout.
    always_comb begin
        wr_dat = {poolop, result_unpool};
        if (poolop) begin
            for (int i = 0; i < X_PE; i++)
                wr_dat[(i*NPIX)*OUT_BIT +: OUT_BIT] = result_pool[i*OUT_BIT +: OUT_BIT];
        end
    end

    // Fullness is judged on the count at the start of the cycle; a same-cycle pop does not help.
    assign wr_en       = in_valid && (cnt_q != CW'(DEPTH));
    assign head        = mem_q[rd_ptr_q];
    assign head_pool   = head[ENTRY_W-1];
    assign fifo_nempty = (cnt_q != '0);
    assign almost_full = (cnt_q >= CW'(DEPTH-2));
    assign overflow    = ovf_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(wr_en);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        cnt_d    = cnt_q + CW'(wr_en) - CW'(pop);
        ovf_d    = ovf_q | (in_valid & ~wr_en);
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_dat;
    end

    // ---------------- serializer FSM ----------------
    // The head entry stays in the FIFO while its pixels are issued; it is popped with its last pixel.
    state_t     state_q, state_d;
    logic [1:0] pix_q, pix_d;
    logic       issue, iss_last;
    logic [1:0] iss_pix;

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q <= IDLE;
            pix_q   <= '0;
        end else begin
            state_q <= state_d;
            pix_q   <= pix_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pix_d   = pix_q;
        case (state_q)
            IDLE: if (!stall && fifo_nempty && !head_pool) begin
                state_d = SEND;
                pix_d   = 2'd1;
            end
            SEND: if (!stall) begin
                if (pix_q == 2'(NPIX-1)) begin
                    state_d = IDLE;
                    pix_d   = '0;
                end else begin
                    pix_d = pix_q + 2'd1;
                end
            end
            default: begin
                state_d = IDLE;
                pix_d   = '0;
            end
        endcase
    end

    // Returning to IDLE after a last pixel still issues the next head the following cycle, so no bubble.
    always_comb begin
        issue    = 1'b0;
        pop      = 1'b0;
        iss_pix  = '0;
        iss_last = 1'b0;
        case (state_q)
            IDLE: if (!stall && fifo_nempty) begin
                issue    = 1'b1;
                iss_last = head_pool;
                pop      = head_pool;
            end
            SEND: if (!stall) begin
                issue    = 1'b1;
                iss_pix  = pix_q;
                iss_last = (pix_q == 2'(NPIX-1));
                pop      = iss_last;
            end
            default: ;
        endcase
    end

    // ---------------- two-stage requant pipeline ----------------
    logic                    s1_vld_q, s1_vld_d, s1_last_q, s1_last_d;
    logic [1:0]              s1_pix_q, s1_pix_d;
    logic signed [OUT_BIT:0] s1_y_q [X_PE];
    logic signed [OUT_BIT:0] s1_y_d [X_PE];
    logic                    s2_vld_q, s2_vld_d, s2_last_q, s2_last_d;
    logic [1:0]              s2_pix_q, s2_pix_d;
    logic [DATA_BIT*X_PE-1:0] dat_q, dat_d;

    assign stall = s2_vld_q && !out_ready;

    always_comb begin
        s1_vld_d  = s1_vld_q;
        s1_pix_d  = s1_pix_q;
        s1_last_d = s1_last_q;
        for (int i = 0; i < X_PE; i++) s1_y_d[i] = s1_y_q[i];
        if (!stall) begin
            s1_vld_d = issue;
            if (issue) begin
                s1_pix_d  = iss_pix;
                s1_last_d = iss_last;
                for (int i = 0; i < X_PE; i++)
                    s1_y_d[i] = rq(head[(i*NPIX + int'(iss_pix))*OUT_BIT +: OUT_BIT], shift, relu_en);
            end
        end
    end

    always_comb begin
        s2_vld_d  = stall ? s2_vld_q : s1_vld_q;
        s2_pix_d  = s2_pix_q;
        s2_last_d = s2_last_q;
        dat_d     = dat_q;
        if (!stall && s1_vld_q) begin
            s2_pix_d  = s1_pix_q;
            s2_last_d = s1_last_q;
            for (int i = 0; i < X_PE; i++) dat_d[i*DATA_BIT +: DATA_BIT] = sat(s1_y_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            s1_vld_q  <= 1'b0;
            s1_pix_q  <= '0;
            s1_last_q <= 1'b0;
            for (int i = 0; i < X_PE; i++) s1_y_q[i] <= '0;
            s2_vld_q  <= 1'b0;
            s2_pix_q  <= '0;
            s2_last_q <= 1'b0;
            dat_q     <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            s1_vld_q  <= s1_vld_d;
            s1_pix_q  <= s1_pix_d;
            s1_last_q <= s1_last_d;
            for (int i = 0; i < X_PE; i++) s1_y_q[i] <= s1_y_d[i];
            s2_vld_q  <= s2_vld_d;
            s2_pix_q  <= s2_pix_d;
            s2_last_q <= s2_last_d;
            dat_q     <= dat_d;
        end
    end

    assign out_valid = s2_vld_q;
    assign out_data  = dat_q;
    assign out_pix   = s2_pix_q;
    assign out_last  = s2_last_q;
endmodule

// File: tb/tb_pe_out_requant.sv
module tb_pe_out_requant;
    localparam int OUT_BIT = 24, DATA_BIT = 8, RESULT_SIZE = 2, X_PE = 16, DEPTH = 8;
    localparam int DW = DATA_BIT * X_PE;
    localparam int CKW = DW + 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                          srst, in_valid, poolop, relu_en, out_ready;
    logic [OUT_BIT*4*X_PE-1:0]     result_unpool;
    logic [OUT_BIT*X_PE-1:0]       result_pool;
    logic [4:0]                    shift;
    logic                          out_valid, out_last, almost_full, overflow;
    logic [DW-1:0]                 out_data;
    logic [1:0]                    out_pix;

    pe_out_requant #(.OUT_BIT(OUT_BIT), .DATA_BIT(DATA_BIT), .RESULT_SIZE(RESULT_SIZE),
                     .X_PE(X_PE), .DEPTH(DEPTH)) dut (
        .clk(clk), .srst(srst), .in_valid(in_valid), .poolop(poolop),
        .result_unpool(result_unpool), .result_pool(result_pool), .shift(shift),
        .relu_en(relu_en), .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .out_pix(out_pix), .out_last(out_last), .almost_full(almost_full), .overflow(overflow));

    typedef struct packed { logic [DW-1:0] dat; logic [1:0] pix; logic last; } beat_t;
    typedef struct { int ch; int x; int sh; bit relu; int expv; } vec_t;

    beat_t exp_q[$];
    vec_t  tbl[16];
    int    n_cmp = 0, n_fail = 0, n_beats = 0, cyc = 0;
    int    first_xfer = -1, last_xfer = -1;
    bit    mon_en = 0, rand_rdy = 0;

    task automatic check(input string name, input logic [CKW-1:0] got, input logic [CKW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Handshake happens at the coming edge with the values visible now; stalled beats must reappear unchanged.
    task automatic step();
        beat_t held;
        bit    hold;
        hold = 0;
        held = '0;
        if (mon_en && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL extra_beat: got beat %h, expected no beat", {out_data, out_pix, out_last});
            end else begin
                check("beat", {out_data, out_pix, out_last}, exp_q.pop_front());
            end
            n_beats++;
            if (first_xfer < 0) first_xfer = cyc;
            last_xfer = cyc;
        end
        if (mon_en && out_valid && !out_ready) begin
            hold = 1;
            held = {out_data, out_pix, out_last};
        end
        @(posedge clk); #1;
        cyc++;
        if (hold) begin
            check("stall_valid", out_valid, 1);
            check("stall_hold", {out_data, out_pix, out_last}, held);
        end
        if (rand_rdy) out_ready = ($urandom_range(0, 2) != 0);
    endtask

    task automatic drain(input int budget, input string name);
        for (int c = 0; c < budget; c++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            step();
        end
        check(name, exp_q.size(), 0);
    endtask

    function automatic int val(int g, int i, int p);
        return ((g * 37 + i * 11 + p * 5) * 97) % 3000 - 1500;
    endfunction

    // Reference: floor((x + half) / 2^s) via integer division with floor correction, then clamp.
    function automatic logic [DATA_BIT-1:0] ref_rq(int x, int s, bit relu);
        longint v, d, n, q;
        v = x;
        if (relu && v < 0) v = 0;
        if (s > 0) begin
            d = longint'(1) << s;
            n = v + d / 2;
            q = n / d;
            if (n < 0 && q * d != n) q = q - 1;
        end else begin
            q = v;
        end
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        return DATA_BIT'(q);
    endfunction

    task automatic send_group(input bit pool, input int g, input bit push);
        beat_t b;
        for (int i = 0; i < X_PE; i++) begin
            for (int p = 0; p < 4; p++)
                result_unpool[(i*4+p)*OUT_BIT +: OUT_BIT] = OUT_BIT'(pool ? val(g + 100, i, p) : val(g, i, p));
            result_pool[i*OUT_BIT +: OUT_BIT] = OUT_BIT'(val(g, i, 0));
        end
        poolop   = pool;
        in_valid = 1'b1;
        if (push) begin
            for (int p = 0; p < (pool ? 1 : 4); p++) begin
                for (int i = 0; i < X_PE; i++)
                    b.dat[i*DATA_BIT +: DATA_BIT] = ref_rq(val(g, i, p), int'(shift), relu_en);
                b.pix  = 2'(p);
                b.last = pool || (p == 3);
                exp_q.push_back(b);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        beat_t b;
        int    nb0, vcount;
        bit    pat5 [5];
        bit    pat8 [8];

        srst = 1; in_valid = 0; poolop = 0; shift = '0; relu_en = 0; out_ready = 1;
        result_unpool = '0; result_pool = '0;
        step(); step();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_pix", out_pix, 0);
        check("rst_out_last", out_last, 0);
        check("rst_almost_full", almost_full, 0);
        check("rst_overflow", overflow, 0);
        srst = 0;
        step();
        mon_en = 1;

        // Unpooled latency: ch0 {100,-100,255,0} -> {50,-50,127,0}; ch15 {-1,1,3,-3} -> {0,1,2,-1}
        shift = 5'd1; relu_en = 0;
        result_unpool = '0;
        result_unpool[0*OUT_BIT +: OUT_BIT] = 24'd100;
        result_unpool[1*OUT_BIT +: OUT_BIT] = -24'sd100;
        result_unpool[2*OUT_BIT +: OUT_BIT] = 24'd255;
        result_unpool[3*OUT_BIT +: OUT_BIT] = 24'd0;
        result_unpool[(60+0)*OUT_BIT +: OUT_BIT] = -24'sd1;
        result_unpool[(60+1)*OUT_BIT +: OUT_BIT] = 24'd1;
        result_unpool[(60+2)*OUT_BIT +: OUT_BIT] = 24'd3;
        result_unpool[(60+3)*OUT_BIT +: OUT_BIT] = -24'sd3;
        b = '0; b.dat[7:0] = 8'd50;            b.dat[127:120] = 8'd0;    b.pix = 2'd0; b.last = 0; exp_q.push_back(b);
        b = '0; b.dat[7:0] = 8'hCE;            b.dat[127:120] = 8'd1;    b.pix = 2'd1; b.last = 0; exp_q.push_back(b);
        b = '0; b.dat[7:0] = 8'd127;           b.dat[127:120] = 8'd2;    b.pix = 2'd2; b.last = 0; exp_q.push_back(b);
        b = '0; b.dat[7:0] = 8'd0;             b.dat[127:120] = 8'hFF;   b.pix = 2'd3; b.last = 1; exp_q.push_back(b);
        poolop = 0; in_valid = 1;
        step();
        in_valid = 0;
        step();
        check("lat_t2_idle", out_valid, 0);
        step();
        check("lat_t3_valid", out_valid, 1);
        for (int k = 0; k < 3; k++) begin
            step();
            check("lat_contig", out_valid, 1);
        end
        step();
        check("lat_after_last", out_valid, 0);
        check("lat_drain", exp_q.size(), 0);

        // Pooled single-channel vectors with hand-computed results
        tbl[0]  = '{0,  8,        4, 0, 1};
        tbl[1]  = '{1,  7,        4, 0, 0};
        tbl[2]  = '{2,  -8,       4, 0, 0};
        tbl[3]  = '{3,  -9,       4, 0, -1};
        tbl[4]  = '{4,  8388607,  4, 0, 127};
        tbl[5]  = '{5,  -8388608, 4, 0, -128};
        tbl[6]  = '{5,  -7,       0, 1, 0};
        tbl[7]  = '{6,  -7,       0, 0, -7};
        tbl[8]  = '{7,  128,      0, 0, 127};
        tbl[9]  = '{8,  -129,     0, 0, -128};
        tbl[10] = '{9,  300,      1, 1, 127};
        tbl[11] = '{10, 8388607,  23, 0, 1};
        tbl[12] = '{11, -8388608, 23, 0, -1};
        tbl[13] = '{15, -3,       1, 1, 0};
        tbl[14] = '{12, 5,        1, 0, 3};
        tbl[15] = '{13, -5,       1, 0, -2};
        for (int r = 0; r < 16; r++) begin
            shift   = 5'(tbl[r].sh);
            relu_en = tbl[r].relu;
            result_unpool = '1;
            result_pool   = '0;
            result_pool[tbl[r].ch*OUT_BIT +: OUT_BIT] = OUT_BIT'(tbl[r].x);
            b = '0;
            b.dat[tbl[r].ch*DATA_BIT +: DATA_BIT] = DATA_BIT'(tbl[r].expv);
            b.pix = 2'd0; b.last = 1;
            exp_q.push_back(b);
            poolop = 1; in_valid = 1;
            step();
            in_valid = 0;
            drain(20, "tbl_drain");
        end

        // Backpressure: 9 unpooled groups with out_ready low; the 9th is dropped
        shift = 5'd2; relu_en = 0; out_ready = 0;
        for (int g = 0; g < 9; g++) begin
            send_group(0, 200 + g, g < 8);
            step();
            check("bp_almost_full", almost_full, (g + 1 >= 6));
            check("bp_overflow", overflow, (g == 8));
        end
        in_valid = 0;
        for (int k = 0; k < 5; k++) step();
        check("bp_af_hold", almost_full, 1);
        nb0 = n_beats;
        out_ready = 1;
        drain(100, "bp_drain");
        check("bp_beat_count", n_beats - nb0, 32);
        check("bp_af_clear", almost_full, 0);

        // Back-to-back mixed groups with out_ready high: 11 beats in one unbroken run
        shift = 5'd3; relu_en = 1;
        pat5 = '{1, 0, 1, 1, 0};
        first_xfer = -1;
        nb0 = n_beats;
        for (int j = 0; j < 5; j++) begin
            send_group(pat5[j], 300 + j, 1);
            step();
        end
        in_valid = 0;
        drain(50, "b2b_drain");
        check("b2b_count", n_beats - nb0, 11);
        check("b2b_span", last_xfer - first_xfer + 1, 11);

        // Same idea with random out_ready; order and stall stability are checked per beat
        shift = 5'd1; relu_en = 0;
        pat8 = '{0, 1, 0, 1, 1, 0, 1, 0};
        rand_rdy = 1;
        for (int j = 0; j < 8; j++) begin
            send_group(pat8[j], 400 + j, 1);
            step();
        end
        in_valid = 0;
        drain(300, "rnd_drain");
        rand_rdy = 0;
        out_ready = 1;

        // Reset in the middle of a group with more groups queued
        shift = 5'd0;
        check("ovf_sticky", overflow, 1);
        for (int j = 0; j < 3; j++) begin
            send_group(0, 500 + j, 1);
            step();
        end
        in_valid = 0;
        nb0 = n_beats;
        for (int c = 0; c < 50 && n_beats < nb0 + 2; c++) step();
        check("mid_beats_seen", n_beats - nb0, 2);
        srst = 1;
        step();
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_overflow", overflow, 0);
        check("mid_rst_af", almost_full, 0);
        check("mid_rst_data", out_data, 0);
        srst = 0;
        exp_q.delete();
        vcount = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (out_valid) vcount++;
        end
        check("mid_no_stale", vcount, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
